syzygy_adc_capture: RTL and testbench

Triggered snapshot buffer that sits directly downstream of the SYZYGY ADC front end. It accepts the deserialized 16-bit channel 1 and channel 2 samples plus the frame-aligned `data_valid` strobe on the ADC divided data clock. On an immediate or threshold trigger it stores a programmed number of sample pairs into internal block RAM. It then exposes that RAM to host-side logic through a synchronous read port.

---
 rtl/syzygy_adc_pkg.sv | 14 +
 rtl/syzygy_adc_capture_if.sv | 21 ++
 rtl/syzygy_adc_capture_ram.sv | 35 +++
 rtl/syzygy_adc_capture.sv | 142 ++++++++++++++
 tb/tb_syzygy_adc_capture.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/syzygy_adc_pkg.sv
// Shared types and constants for the SYZYGY ADC snapshot capture block.
package syzygy_adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capture_state_t;

  localparam logic TRIG_IMMEDIATE = 1'b0;
  localparam logic TRIG_THRESHOLD = 1'b1;

endpackage

// File: rtl/syzygy_adc_capture_if.sv
// Deserialized two-channel ADC sample stream. data_valid qualifies both channels;
// there is no back-pressure: the capture side must accept every valid sample.
interface syzygy_adc_capture_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] adc_data_1;
  logic [DATA_W-1:0] adc_data_2;
  logic              data_valid;

  modport master (
    output adc_data_1,
    output adc_data_2,
    output data_valid
  );

  modport slave (
    input adc_data_1,
    input adc_data_2,
    input data_valid
  );
endinterface

// File: rtl/syzygy_adc_capture_ram.sv
// Simple dual-port block RAM: one write port, registered read-first read port.
module syzygy_adc_capture_ram #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Only the output register is reset; the array itself is left uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/syzygy_adc_capture.sv
// Triggered snapshot buffer: arms, waits for an immediate or threshold trigger,
// stores a programmed number of {ch2, ch1} pairs, then holds them for host reads.
module syzygy_adc_capture
  import syzygy_adc_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  syzygy_adc_capture_if.slave     adc,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    trig_mode,
  input  logic [DATA_W-1:0]       threshold,
  input  logic [DEPTH_LOG2:0]     capture_len,
  input  logic [DEPTH_LOG2-1:0]   rd_addr,
  output logic [2*DATA_W-1:0]     rd_data,
  output logic                    armed,
  output logic                    busy,
  output logic                    done,
  output logic [DEPTH_LOG2:0]     sample_count,
  output capture_state_t          dbg_state_o
);

  localparam logic [DEPTH_LOG2:0] DEPTH_V = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE_V   = {{DEPTH_LOG2{1'b0}}, 1'b1};

  capture_state_t          state_q, state_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic [DEPTH_LOG2:0]     len_q, len_d;
  logic [DATA_W-1:0]       prev_q, prev_d;
  logic                    hist_q, hist_d;
  logic                    armed_q, busy_q, done_q;

  logic                    wr_en;
  logic [DEPTH_LOG2-1:0]   wr_addr;
  logic [DEPTH_LOG2:0]     len_clamped;
  logic                    trig_hit;

  assign len_clamped = (capture_len == '0 || capture_len > DEPTH_V) ? DEPTH_V : capture_len;

  // hist_q blocks a threshold trigger until one valid ch1 sample has been seen while armed.
  always_comb begin
    trig_hit = 1'b0;
    if (adc.data_valid) begin
      if (trig_mode == TRIG_IMMEDIATE) begin
        trig_hit = 1'b1;
      end else begin
        trig_hit = hist_q && (prev_q < threshold) && (adc.adc_data_1 >= threshold);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    prev_d  = prev_q;
    hist_d  = hist_q;
    wr_en   = 1'b0;
    wr_addr = count_q[DEPTH_LOG2-1:0];
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_d = ARMED;
            len_d   = len_clamped;
            count_d = '0;
            prev_d  = '0;
            hist_d  = 1'b0;
          end
        end
        ARMED: begin
          if (trig_hit) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            count_d = ONE_V;
            state_d = (len_q == ONE_V) ? DONE : CAPTURE;
          end else if (adc.data_valid) begin
            prev_d = adc.adc_data_1;
            hist_d = 1'b1;
          end
        end
        CAPTURE: begin
          if (adc.data_valid) begin
            wr_en   = 1'b1;
            count_d = count_q + ONE_V;
            if (count_d == len_q) begin
              state_d = DONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= DEPTH_V;
      prev_q  <= '0;
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      prev_q  <= prev_d;
      hist_q  <= hist_d;
      armed_q <= (state_d == ARMED);
      busy_q  <= (state_d == CAPTURE);
      done_q  <= (state_d == DONE);
    end
  end

  syzygy_adc_capture_ram #(
    .ADDR_W (DEPTH_LOG2),
    .WORD_W (2*DATA_W)
  ) u_ram (
    .clk       (clk),
    .rst_n     (reset_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i ({adc.adc_data_2, adc.adc_data_1}),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign armed        = armed_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_count = count_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_syzygy_adc_capture.sv
// Self-checking bench for syzygy_adc_capture: capture scenarios feed a scoreboard
// queue of expected RAM words that is drained through the read port.
module tb_syzygy_adc_capture;
  import syzygy_adc_pkg::*;

  localparam int DEPTH_LOG2 = 10;
  localparam int DATA_W     = 16;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                  clk;
  logic                  reset_n;
  logic                  arm;
  logic                  abort;
  logic                  trig_mode;
  logic [DATA_W-1:0]     threshold;
  logic [DEPTH_LOG2:0]   capture_len;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [2*DATA_W-1:0]   rd_data;
  logic                  armed;
  logic                  busy;
  logic                  done;
  logic [DEPTH_LOG2:0]   sample_count;
  capture_state_t        dbg_state;

  logic [2*DATA_W-1:0] exp_q[$];
  int n_vec;
  int n_err;

  syzygy_adc_capture_if #(.DATA_W(DATA_W)) adc_if ();

  syzygy_adc_capture #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .adc          (adc_if.slave),
    .arm          (arm),
    .abort        (abort),
    .trig_mode    (trig_mode),
    .threshold    (threshold),
    .capture_len  (capture_len),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .armed        (armed),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] c1, input logic [DATA_W-1:0] c2);
    adc_if.data_valid = v;
    adc_if.adc_data_1 = c1;
    adc_if.adc_data_2 = c2;
    step();
  endtask

  task automatic idle_input();
    adc_if.data_valid = 1'b0;
    adc_if.adc_data_1 = '0;
    adc_if.adc_data_2 = '0;
  endtask

  task automatic do_arm(input logic mode, input logic [DATA_W-1:0] thr, input logic [DEPTH_LOG2:0] len);
    idle_input();
    trig_mode   = mode;
    threshold   = thr;
    capture_len = len;
    arm         = 1'b1;
    step();
    arm         = 1'b0;
    check("arm_armed", armed, 1'b1);
    check("arm_count", sample_count, '0);
  endtask

  task automatic readback(input int n, input string tag);
    logic [2*DATA_W-1:0] exp_w;
    for (int i = 0; i < n; i++) begin
      rd_addr = i[DEPTH_LOG2-1:0];
      step();
      check({tag, "_sb_avail"}, exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check({tag, "_rd_data"}, rd_data, exp_w);
      end
    end
    check({tag, "_sb_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [DATA_W-1:0] c1;
    logic [DATA_W-1:0] c2;
    logic [DEPTH_LOG2:0] clamp_lens [2];
    n_vec = 0;
    n_err = 0;
    reset_n     = 1'b0;
    arm         = 1'b0;
    abort       = 1'b0;
    trig_mode   = TRIG_IMMEDIATE;
    threshold   = '0;
    capture_len = '0;
    rd_addr     = '0;
    idle_input();
    repeat (3) step();
    check("rst_armed", armed, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count", sample_count, '0);
    check("rst_rd_data", rd_data, '0);
    check("rst_state", dbg_state, IDLE);
    reset_n = 1'b1;
    step();

    // immediate trigger, ramp 0..7
    do_arm(TRIG_IMMEDIATE, '0, 8);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({i[DATA_W-1:0], i[DATA_W-1:0]});
      drive(1'b1, i[DATA_W-1:0], i[DATA_W-1:0]);
      check("imm_busy", busy, (i < 7));
      check("imm_done", done, (i == 7));
      check("imm_count", sample_count, i + 1);
    end
    drive(1'b1, 16'h55AA, 16'hAA55);
    check("imm_hold_count", sample_count, 8);
    check("imm_hold_done", done, 1'b1);
    idle_input();
    readback(8, "imm");

    // threshold crossing: a lone 0x0900 has no history; 0x07FF -> 0x0800 fires
    do_arm(TRIG_THRESHOLD, 16'h0800, 4);
    drive(1'b0, 16'h0000, 16'h0000);
    check("thr_novalid_armed", armed, 1'b1);
    drive(1'b1, 16'h0900, 16'hA000);
    check("thr_first_armed", armed, 1'b1);
    check("thr_first_count", sample_count, 0);
    drive(1'b1, 16'h07FF, 16'hA001);
    check("thr_below_armed", armed, 1'b1);
    exp_q.push_back({16'hA002, 16'h0800});
    drive(1'b1, 16'h0800, 16'hA002);
    check("thr_trig_busy", busy, 1'b1);
    check("thr_trig_count", sample_count, 1);
    exp_q.push_back({16'hA003, 16'h0900});
    drive(1'b1, 16'h0900, 16'hA003);
    exp_q.push_back({16'hA004, 16'h0100});
    drive(1'b1, 16'h0100, 16'hA004);
    exp_q.push_back({16'hA005, 16'h0200});
    drive(1'b1, 16'h0200, 16'hA005);
    check("thr_done", done, 1'b1);
    check("thr_count", sample_count, 4);
    idle_input();
    readback(4, "thr");

    // gapped data_valid
    do_arm(TRIG_IMMEDIATE, '0, 4);
    for (int k = 0; k < 8; k++) begin
      c1 = DATA_W'($urandom_range(0, 16'hFFFF));
      c2 = DATA_W'($urandom_range(0, 16'hFFFF));
      if (k % 2 == 0) exp_q.push_back({c2, c1});
      drive((k % 2 == 0), c1, c2);
      check("gap_done", done, (k >= 6));
      check("gap_count", sample_count, (k / 2 + 1));
    end
    idle_input();
    readback(4, "gap");

    // length clamp
    clamp_lens[0] = '0;
    clamp_lens[1] = (DEPTH_LOG2 + 1)'(DEPTH + 5);
    for (int t = 0; t < 2; t++) begin
      do_arm(TRIG_IMMEDIATE, '0, clamp_lens[t]);
      for (int i = 0; i < DEPTH; i++) begin
        c1 = DATA_W'($urandom_range(0, 16'hFFFF));
        c2 = DATA_W'($urandom_range(0, 16'hFFFF));
        exp_q.push_back({c2, c1});
        drive(1'b1, c1, c2);
        if (i == DEPTH - 2) check("clamp_busy", busy, 1'b1);
      end
      check("clamp_done", done, 1'b1);
      check("clamp_count", sample_count, DEPTH);
      drive(1'b1, 16'hDEAD, 16'hBEEF);
      check("clamp_hold_count", sample_count, DEPTH);
      idle_input();
      readback(DEPTH, "clamp");
    end

    // abort in the same cycle as a qualifying sample
    do_arm(TRIG_IMMEDIATE, '0, 8);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({16'hC000 + i[DATA_W-1:0], 16'h3000 + i[DATA_W-1:0]});
      drive(1'b1, 16'h3000 + i[DATA_W-1:0], 16'hC000 + i[DATA_W-1:0]);
    end
    check("abort_pre_count", sample_count, 3);
    abort = 1'b1;
    drive(1'b1, 16'h3FFF, 16'hCFFF);
    abort = 1'b0;
    check("abort_armed", armed, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_count", sample_count, 3);
    check("abort_state", dbg_state, IDLE);
    idle_input();
    readback(3, "abort");
    arm   = 1'b1;
    abort = 1'b1;
    step();
    arm   = 1'b0;
    abort = 1'b0;
    check("abort_over_arm", armed, 1'b0);

    // async reset mid-capture, then a normal capture
    do_arm(TRIG_IMMEDIATE, '0, 8);
    drive(1'b1, 16'h1111, 16'h2222);
    drive(1'b1, 16'h3333, 16'h4444);
    rd_addr = '0;
    check("ar_busy_before", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_armed", armed, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_done", done, 1'b0);
    check("ar_count", sample_count, 0);
    check("ar_rd_data", rd_data, 0);
    check("ar_state", dbg_state, IDLE);
    idle_input();
    step();
    reset_n = 1'b1;
    step();
    do_arm(TRIG_IMMEDIATE, '0, 5);
    for (int i = 0; i < 5; i++) begin
      c1 = DATA_W'($urandom_range(0, 16'hFFFF));
      c2 = DATA_W'($urandom_range(0, 16'hFFFF));
      exp_q.push_back({c2, c1});
      drive(1'b1, c1, c2);
    end
    check("ar_post_done", done, 1'b1);
    check("ar_post_count", sample_count, 5);
    idle_input();
    readback(5, "ar_post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
